// File: rtl/fmap_collector_pkg.sv
// Shared types and constants for the feature-map collector: FSM states and pixel width.
package fmap_collector_pkg;

    localparam int PIX_W  = 8;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } fmap_state_t;

endpackage

// File: rtl/fmap_byte_ram.sv
// Pixel store: one 32-bit word written as four consecutive bytes, one byte read combinationally.
module fmap_byte_ram
    import fmap_collector_pkg::*;
#(
    parameter int DEPTH = 169
) (
    input  logic              clk,
    input  logic              we,
    input  logic [7:0]        waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [7:0]        raddr,
    output logic [PIX_W-1:0]  rdata
);

    localparam logic [8:0] DEPTH9 = 9'(DEPTH);

    logic [PIX_W-1:0] mem [DEPTH];

    // Bytes that land past the end of the frame (tail of the last word) are dropped here.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we && (({1'b0, waddr} + 9'(k)) < DEPTH9)) begin
                mem[waddr + 8'(k)] <= wdata[k*PIX_W +: PIX_W];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fmap_collector.sv
// Collects packed PE result words into a frame buffer, then streams it out pixel by pixel
// with row/column coordinates.
module fmap_collector
    import fmap_collector_pkg::*;
#(
    parameter int OUT_SIZE  = 13,
    parameter int NUM_WORDS = (OUT_SIZE*OUT_SIZE + 3) / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_data,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    localparam logic [7:0] LAST_WORD = 8'(NUM_WORDS - 1);
    localparam logic [7:0] LAST_PIX  = 8'(OUT_SIZE*OUT_SIZE - 1);
    localparam logic [7:0] LAST_COL  = 8'(OUT_SIZE - 1);

    fmap_state_t      state, state_nxt;
    logic [7:0]       word_cnt;
    logic [7:0]       pix_cnt;
    logic [PIX_W-1:0] ram_rdata;
    logic             accept;
    logic             take;

    // A transfer happens on a rising edge where valid and ready are both high; valid never
    // depends on ready, and the payload holds while valid is high and ready is low.
    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = COLLECT;
            end
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && (word_cnt == LAST_WORD)) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (pix_cnt == LAST_PIX)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
            pix_cnt  <= '0;
            out_row  <= '0;
            out_col  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        word_cnt <= '0;
                        pix_cnt  <= '0;
                        out_row  <= '0;
                        out_col  <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) word_cnt <= word_cnt + 8'd1;
                end
                DRAIN: begin
                    if (take) begin
                        pix_cnt <= pix_cnt + 8'd1;
                        if (out_col == LAST_COL) begin
                            out_col <= '0;
                            out_row <= out_row + 8'd1;
                        end else begin
                            out_col <= out_col + 8'd1;
                        end
                    end
                end
                DONE: begin
                    word_cnt <= '0;
                    pix_cnt  <= '0;
                    out_row  <= '0;
                    out_col  <= '0;
                end
                default: ;
            endcase
        end
    end

    fmap_byte_ram #(
        .DEPTH(OUT_SIZE*OUT_SIZE)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (word_cnt << 2),
        .wdata (in_word),
        .raddr (pix_cnt),
        .rdata (ram_rdata)
    );

    assign out_data  = out_valid ? ram_rdata : '0;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_fmap_collector.sv
// Self-checking bench for fmap_collector: scoreboard of expected pixels filled as words are sent.
module tb_fmap_collector;
    import fmap_collector_pkg::*;

    localparam int OUT_SIZE  = 13;
    localparam int NUM_WORDS = 43;
    localparam int NPIX      = OUT_SIZE*OUT_SIZE;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [7:0]  out_row;
    logic [7:0]  out_col;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;

    logic [23:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    fmap_collector #(.OUT_SIZE(OUT_SIZE), .NUM_WORDS(NUM_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: start pulse then nwords accepted words; expected pixels pushed on each drive
    task automatic collect(input int nwords, input bit gaps, input bit rnd,
                           input bit use_last, input logic [31:0] last_word);
        logic [31:0] word;
        logic [7:0]  wb;
        int w;
        int budget;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (state_dbg !== 2'(COLLECT) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL collect_entry: state=%0d busy=%b expected state=%0d busy=1",
                     state_dbg, busy, 2'(COLLECT));
        end
        w = 0;
        budget = 0;
        while (w < nwords && budget < 1000) begin
            if (gaps && (budget % 2 == 1)) begin
                in_valid = 1'b0;
                in_word  = $urandom;
            end else begin
                wb   = 8'(4*w);
                word = rnd ? $urandom : (32'h03020100 + {wb, wb, wb, wb});
                if (use_last && w == NUM_WORDS-1) word = last_word;
                in_valid = 1'b1;
                in_word  = word;
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL in_ready_collect: word=%0d got %b expected 1", w, in_ready);
                end
                for (int k = 0; k < 4; k++) begin
                    int p;
                    p = 4*w + k;
                    if (p < NPIX) exp_q.push_back({word[8*k +: 8], 8'(p / OUT_SIZE), 8'(p % OUT_SIZE)});
                end
                w++;
            end
            step();
            budget++;
        end
        in_valid = 1'b0;
        if (nwords == NUM_WORDS) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_dbg !== 2'(DRAIN)) begin
                n_fail++;
                $display("FAIL drain_latency: out_valid=%b in_ready=%b state=%0d expected 1 0 %0d",
                         out_valid, in_ready, state_dbg, 2'(DRAIN));
            end
        end
    endtask

    // scoreboard: compare each presented pixel with the queue head, pop on handshake
    task automatic drain(input int stall_pix, input bit poke);
        int p;
        int stall_left;
        int budget;
        p = 0;
        stall_left = 5;
        budget = 0;
        while (p < NPIX && budget < 2000) begin
            out_ready = 1'b1;
            if (p == stall_pix && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            if (poke) begin
                start    = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
                in_word  = $urandom;
            end
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_ctrl: pix=%0d out_valid=%b in_ready=%b done=%b expected 1 0 0",
                         p, out_valid, in_ready, done);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: pix=%0d got %h with no expected entry", p,
                         {out_data, out_row, out_col});
            end else if ({out_data, out_row, out_col} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL pixel: pix=%0d got data/row/col %h expected %h", p,
                         {out_data, out_row, out_col}, exp_q[0]);
            end
            if (out_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                p++;
            end
            step();
            budget++;
        end
        n_checks++;
        if (p != NPIX) begin
            n_fail++;
            $display("FAIL drain_timeout: drained %0d pixels expected %0d", p, NPIX);
        end
        start    = poke;
        in_valid = poke;
        out_ready = 1'b1;
        n_checks++;
        if (done !== 1'b1 || state_dbg !== 2'(DONE) || out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b state=%0d out_valid=%b out_data=%h expected 1 %0d 0 00",
                     done, state_dbg, out_valid, out_data, 2'(DONE));
        end
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'(IDLE) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL after_done: done=%b busy=%b state=%0d leftover=%0d expected 0 0 %0d 0",
                     done, busy, state_dbg, exp_q.size(), 2'(IDLE));
        end
        step();
        n_checks++;
        if (state_dbg !== 2'(IDLE) || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: state=%0d in_ready=%b expected %0d 0", state_dbg, in_ready, 2'(IDLE));
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_checks++;
        if (state_dbg !== 2'(IDLE) || in_ready !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || out_data !== 8'h00 ||
            out_row !== 8'h00 || out_col !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d in_ready=%b out_valid=%b busy=%b done=%b data=%h row=%h col=%h expected all zero",
                     state_dbg, in_ready, out_valid, busy, done, out_data, out_row, out_col);
        end
        step();
        step();
        rst = 1'b1;
        step();
        // in_valid while idle must not be accepted
        in_valid = 1'b1;
        in_word  = 32'hFFFF_FFFF;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: in_ready=%b busy=%b expected 0 0", in_ready, busy);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        collect(NUM_WORDS, 1'b0, 1'b0, 1'b0, 32'h0);
        drain(-1, 1'b0);
    endtask

    task automatic test_gapped_input();
        collect(NUM_WORDS, 1'b1, 1'b1, 1'b0, 32'h0);
        drain(-1, 1'b0);
    endtask

    task automatic test_backpressure();
        collect(NUM_WORDS, 1'b0, 1'b0, 1'b0, 32'h0);
        drain(3*OUT_SIZE + 7, 1'b0);
    endtask

    task automatic test_last_word_discard();
        logic [23:0] last;
        collect(NUM_WORDS, 1'b0, 1'b0, 1'b1, 32'hDEADBE55);
        last = exp_q[exp_q.size()-1];
        n_checks++;
        if (last !== {8'h55, 8'd12, 8'd12} || exp_q.size() != NPIX) begin
            n_fail++;
            $display("FAIL last_word_model: tail=%h size=%0d expected 550c0c %0d", last, exp_q.size(), NPIX);
        end
        drain(-1, 1'b0);
    endtask

    task automatic test_reset_mid_collect();
        collect(20, 1'b0, 1'b1, 1'b0, 32'h0);
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (state_dbg !== 2'(IDLE) || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d in_ready=%b busy=%b expected %0d 0 0",
                     state_dbg, in_ready, busy, 2'(IDLE));
        end
        exp_q.delete();
        step();
        rst = 1'b1;
        step();
        collect(NUM_WORDS, 1'b0, 1'b1, 1'b0, 32'h0);
        drain(-1, 1'b0);
    endtask

    task automatic test_ignore_in_drain_done();
        collect(NUM_WORDS, 1'b0, 1'b1, 1'b0, 32'h0);
        drain(50, 1'b1);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gapped_input();
        test_backpressure();
        test_last_word_discard();
        test_reset_mid_collect();
        test_ignore_in_drain_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fmap_collector.md
FMAP_COLLECTOR -- requirements
Module: fmap_collector

Interface
REQ-001 Parameter OUT_SIZE, default 13, meaning the output feature-map side in pixels (16-pixel image, 4x4 filter).
REQ-002 Parameter NUM_WORDS, default ceil(OUT_SIZE*OUT_SIZE/4) = 43, meaning the packed 32-bit result words per frame.
REQ-003 clk  input  1  meaning the single clock; all state changes on the rising edge.
REQ-004 rst  input  1  meaning the reset: asynchronous, active-low.
REQ-005 start  input  1  meaning a one-cycle request to begin collecting a frame.
REQ-006 in_valid  input  1  meaning in_word holds a PE result word.
REQ-007 in_word  input  32  meaning four packed 8-bit pixels; bits [8k+7:8k] hold pixel 4*w+k of word w.
REQ-008 in_ready  output  1  meaning the block accepts in_word this cycle.
REQ-009 out_valid  output  1  meaning out_data, out_row and out_col hold a pixel.
REQ-010 out_ready  input  1  meaning the downstream stage takes the pixel.
REQ-011 out_data  output  8  meaning the pixel value.
REQ-012 out_row, out_col  output  8 each  meaning the pixel coordinates, row-major.
REQ-013 busy  output  1  meaning high whenever the state is not IDLE.
REQ-014 done  output  1  meaning a one-cycle pulse when the frame has fully drained.

Function
REQ-015 The block SHALL implement the FSM states IDLE, COLLECT, DRAIN and DONE.
REQ-016 IDLE->COLLECT SHALL occur on start=1; start in any other state SHALL be ignored.
REQ-017 COLLECT: in_ready=1; each cycle with in_valid&in_ready SHALL write 4 bytes into internal byte storage at pixel 4*word_cnt+k and increment word_cnt.
REQ-018 Bytes of the last word with pixel index >= OUT_SIZE*OUT_SIZE SHALL be discarded (default: bytes 1..3 of word 42).
REQ-019 Acceptance of word NUM_WORDS-1 SHALL move the FSM to DRAIN on the next edge, with in_ready=0 from that cycle on.
REQ-020 DRAIN: out_valid=1 from the first DRAIN cycle, presenting pixel 0 (row 0, col 0); latency from the last accepted word to the first out_valid is 1 cycle.
REQ-021 Each out_valid&out_ready SHALL advance the pixel; col wraps from OUT_SIZE-1 to 0 with row incremented.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_row and out_col SHALL hold stable.
REQ-023 The handshake on pixel (OUT_SIZE-1, OUT_SIZE-1) SHALL move the FSM to DONE; DONE asserts done=1 for exactly one cycle, then returns to IDLE.
REQ-024 in_valid outside COLLECT SHALL be ignored (in_ready=0) and SHALL NOT alter storage.
REQ-025 start arriving in the DONE cycle SHALL be ignored; a new frame needs start in IDLE.
REQ-026 Word and pixel counters SHALL be 8 bits wide, and compare against NUM_WORDS-1 and OUT_SIZE*OUT_SIZE-1 without wrap.

Reset
REQ-027 rst=0 SHALL force IDLE asynchronously, with word_cnt, the pixel counter, out_row and out_col at 0, and in_ready, out_valid, busy and done at 0.
REQ-028 Reset mid-COLLECT or mid-DRAIN SHALL abandon the frame; byte storage need not be cleared.
REQ-029 out_data SHALL be 0 while out_valid=0.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (fmap_state_t) and the pixel-width constant PIX_W=8.
REQ-031 One sub-module, fmap_byte_ram (OUT_SIZE*OUT_SIZE x 8, 4-byte write, 1-byte read), is natural; the FSM and counters stay in fmap_collector.

Verification
REQ-032 Reset, then start, then 43 back-to-back words with in_word=32'h03020100+{4w,4w,4w,4w}, out_ready=1 -> 169 pixels with out_data=pixel index, last at (12,12); done pulses once; busy falls.
REQ-033 in_valid toggled 1/0 during COLLECT -> only valid cycles counted; DRAIN starts exactly 1 cycle after the 43rd accepted word.
REQ-034 out_ready held 0 for 5 cycles at pixel (3,7) -> outputs stable for 5 cycles; the next pixel is (3,8), and no pixel is lost or duplicated.
REQ-035 Last word 32'hDEADBE55 -> pixel 168=8'h55; bytes BE, AD and DE never appear at the output.
REQ-036 rst asserted at word 20 of COLLECT, then a fresh start and a full frame -> new frame output correct; no done before the full drain.
REQ-037 start and in_valid pulsed in DRAIN and DONE -> no state change, in_ready stays 0, output sequence unaffected.
